// File: rtl/sum_hex_display.sv
// Binary-to-BCD (double-dabble, one bit per clock) conversion feeding four active-low 7-segment digits.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros on HEX3..HEX1.
module sum_hex_display #(
  parameter int WIDTH = 10
) (
  input  logic             CLOCK_50,
  input  logic             Reset,
  input  logic [WIDTH-1:0] data,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [6:0]       HEX0,
  output logic [6:0]       HEX1,
  output logic [6:0]       HEX2,
  output logic [6:0]       HEX3
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [3:0][6:0] RESET_DISP = {7'h7F, 7'h7F, 7'h7F, 7'h40};
`else
  localparam logic [3:0][6:0] RESET_DISP = {7'h40, 7'h40, 7'h40, 7'h40};
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [15:0]      bcd_q, bcd_d, bcd_adj;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [3:0][6:0]  hex_q, hex_d;
  logic [3:0]       blank;

  function automatic logic [6:0] seg7(input logic [3:0] digit);
    case (digit)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  // Add-3 correction applied to every nibble before the shift.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
    end
  end

  // A zero digit is blanked only if all more-significant digits are zero too.
  always_comb begin
    blank = '0;
`ifdef LEADING_ZERO_BLANK_EN
    blank[3] = (bcd_q[15:12] == 4'd0);
    blank[2] = blank[3] && (bcd_q[11:8] == 4'd0);
    blank[1] = blank[2] && (bcd_q[7:4] == 4'd0);
`endif
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path can leave it unassigned and infer a latch.
    state_d = state_q;
    shift_d = shift_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    hex_d   = hex_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CONV;
          shift_d = data;
          bcd_d   = '0;
          cnt_d   = CW'(WIDTH);
          busy_d  = 1'b1;
        end
      end
      CONV: begin
        bcd_d   = {bcd_adj[14:0], shift_q[WIDTH-1]};
        shift_d = shift_q << 1;
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) state_d = LOAD;
      end
      LOAD: begin
        for (int i = 0; i < 4; i++) begin
          hex_d[i] = blank[i] ? 7'h7F : seg7(bcd_q[4*i +: 4]);
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from the same pre-edge values.
  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hex_q   <= RESET_DISP;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hex_q   <= hex_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign HEX0 = hex_q[0];
  assign HEX1 = hex_q[1];
  assign HEX2 = hex_q[2];
  assign HEX3 = hex_q[3];

endmodule

// File: tb/tb_sum_hex_display.sv
// Directed bench for sum_hex_display: scoreboard of expected HEX words, popped on each done pulse.
module tb_sum_hex_display;

  logic        CLOCK_50 = 1'b0;
  logic        Reset;
  logic [9:0]  data;
  logic        start;
  logic        busy, done;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3;

  logic [12:0] data13;
  logic        start13;
  logic        busy13, done13;
  logic [6:0]  H13_0, H13_1, H13_2, H13_3;

  int tests = 0;
  int fails = 0;
  logic [31:0] sb[$];

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [31:0] RST_DISP = 32'({7'h7F, 7'h7F, 7'h7F, 7'h40});
`else
  localparam logic [31:0] RST_DISP = 32'({7'h40, 7'h40, 7'h40, 7'h40});
`endif

  sum_hex_display #(.WIDTH(10)) dut (
    .CLOCK_50(CLOCK_50), .Reset(Reset), .data(data), .start(start),
    .busy(busy), .done(done), .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3)
  );

  sum_hex_display #(.WIDTH(13)) dut13 (
    .CLOCK_50(CLOCK_50), .Reset(Reset), .data(data13), .start(start13),
    .busy(busy13), .done(done13), .HEX0(H13_0), .HEX1(H13_1), .HEX2(H13_2), .HEX3(H13_3)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  function automatic logic [6:0] seg_of(input int d);
    logic [6:0] tbl [10];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return tbl[d];
  endfunction

  // Independent reference: decimal digits by division, then segment lookup and optional blanking.
  function automatic logic [31:0] model(input int v);
    int d [4];
    logic [6:0] s [4];
    bit lead;
    d[0] = v % 10; d[1] = (v / 10) % 10; d[2] = (v / 100) % 10; d[3] = (v / 1000) % 10;
    lead = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      s[i] = seg_of(d[i]);
`ifdef LEADING_ZERO_BLANK_EN
      if (i > 0 && lead && d[i] == 0) s[i] = 7'h7F;
`endif
      if (d[i] != 0) lead = 1'b0;
    end
    return 32'({s[3], s[2], s[1], s[0]});
  endfunction

  function automatic logic [31:0] hexes();
    return 32'({HEX3, HEX2, HEX1, HEX0});
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock, then sample; every done pulse must match the oldest scoreboard entry.
  task automatic step();
    logic [31:0] e;
    @(posedge CLOCK_50);
    #1;
    if (done) begin
      chk("done_has_pending_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_hex", hexes(), e);
      end
    end
  endtask

  task automatic kick(input int v);
    data  = 10'(v);
    start = 1'b1;
    sb.push_back(model(v));
    step();
    chk("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!done && cycles < 40) begin
      step();
      cycles++;
      if (!done) chk("busy_during_conv", 32'(busy), 32'd1);
    end
    chk("done_seen", 32'(done), 32'd1);
    chk("busy_low_at_done", 32'(busy), 32'd0);
  endtask

  initial begin
    int cyc;
    Reset = 1'b1; start = 1'b0; data = '0; start13 = 1'b0; data13 = '0;
    #3;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_hex", hexes(), RST_DISP);
    chk("rst_hex13", 32'({H13_3, H13_2, H13_1, H13_0}), RST_DISP);
    @(posedge CLOCK_50); @(negedge CLOCK_50);
    Reset = 1'b0;
    step();

    // 1023: busy through the conversion, done exactly WIDTH+1 cycles after the start edge.
    kick(1023);
    start = 1'b0;
    wait_done(cyc);
    chk("lat_1023", 32'(cyc), 32'd11);
    chk("hex_1023", hexes(), 32'({7'h79, 7'h40, 7'h24, 7'h30}));
    step();
    chk("done_one_cycle", 32'(done), 32'd0);

    // Zero exercises leading-zero handling.
    kick(0);
    start = 1'b0;
    wait_done(cyc);
`ifdef LEADING_ZERO_BLANK_EN
    chk("hex_0", hexes(), 32'({7'h7F, 7'h7F, 7'h7F, 7'h40}));
`else
    chk("hex_0", hexes(), 32'({7'h40, 7'h40, 7'h40, 7'h40}));
`endif
    step();

    // 5, then data changes and start stays high while busy: ignored.
    kick(5);
    data = 10'd999;
    wait_done(cyc);
    start = 1'b0;
    chk("hex0_5", 32'(HEX0), 32'h12);
    for (int i = 0; i < 14; i++) begin
      step();
      chk("no_second_done", 32'(done), 32'd0);
    end

    // 204 then 560 started in the done cycle.
    kick(204);
    start = 1'b0;
    wait_done(cyc);
    kick(560);
    start = 1'b0;
    wait_done(cyc);
    chk("lat_b2b", 32'(cyc), 32'd11);
    chk("hex_560", 32'({HEX2, HEX1, HEX0}), 32'({7'h12, 7'h02, 7'h40}));
    step();

    // Asynchronous reset in the middle of converting 987.
    kick(987);
    start = 1'b0;
    step(); step(); step();
    #2;
    Reset = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_hex", hexes(), RST_DISP);
    sb.delete();
    @(posedge CLOCK_50);
    #2;
    Reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      chk("no_done_after_rst", 32'(done | busy), 32'd0);
    end

    // WIDTH=13 instance at its maximum value.
    data13  = 13'd8191;
    start13 = 1'b1;
    @(posedge CLOCK_50); #1;
    start13 = 1'b0;
    cyc = 0;
    while (!done13 && cyc < 40) begin
      @(posedge CLOCK_50); #1;
      cyc++;
    end
    chk("done13_seen", 32'(done13), 32'd1);
    chk("lat13", 32'(cyc), 32'd14);
    chk("hex_8191", 32'({H13_3, H13_2, H13_1, H13_0}), 32'({7'h00, 7'h79, 7'h10, 7'h79}));
    chk("model_8191", 32'({H13_3, H13_2, H13_1, H13_0}), model(8191));

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
